// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers. Each channel produces a
// one-cycle tick and a 50% duty clk_out level. A new divisor is held as
// pending and takes effect only at the next wrap, or immediately when the
// channel is disabled, so the output streams never glitch.
module clk_div_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned DEFAULT_DIV = 50000,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    logic [CNT_W-1:0]  count       [NUM_CH];
    logic [CNT_W-1:0]  active_div  [NUM_CH];
    logic [CNT_W-1:0]  pending_div [NUM_CH];
    logic [NUM_CH-1:0] pend_flag;

    logic              wr_ok_c;
    logic [NUM_CH-1:0] wr_hit_c;

    // A write is legal for a non-zero divisor aimed at an existing channel.
    assign wr_ok_c = div_wr && (div_val != '0) && (32'(div_ch) < NUM_CH);

    // One-hot decode of the accepted write onto its target channel.
    always_comb begin
        wr_hit_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = wr_ok_c && (div_ch == CH_W'(i));
        end
    end

    // Per-channel counter, tick/clk_out generation and divisor hand-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i]       <= '0;
                active_div[i]  <= CNT_W'(DEFAULT_DIV);
                pending_div[i] <= CNT_W'(DEFAULT_DIV);
            end
            pend_flag <= '0;
            tick      <= '0;
            clk_out   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en[i]) begin
                    // Idle channel: clear outputs; divisor changes apply at once.
                    count[i]   <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                    if (wr_hit_c[i]) begin
                        active_div[i]  <= div_val;
                        pending_div[i] <= div_val;
                    end else if (pend_flag[i]) begin
                        active_div[i] <= pending_div[i];
                    end
                    pend_flag[i] <= 1'b0;
                end else if (count[i] == active_div[i] - CNT_W'(1)) begin
                    // Wrap: this period used the old divisor; load the new one.
                    count[i]   <= '0;
                    tick[i]    <= 1'b1;
                    clk_out[i] <= ~clk_out[i];
                    if (wr_hit_c[i]) begin
                        active_div[i]  <= div_val;
                        pending_div[i] <= div_val;
                    end else if (pend_flag[i]) begin
                        active_div[i] <= pending_div[i];
                    end
                    pend_flag[i] <= 1'b0;
                end else begin
                    // Mid-period: keep counting, park any new divisor.
                    count[i] <= count[i] + CNT_W'(1);
                    tick[i]  <= 1'b0;
                    if (wr_hit_c[i]) begin
                        pending_div[i] <= div_val;
                        pend_flag[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    // Write handshake pulses, mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_ack <= wr_ok_c;
            div_err <= div_wr && !wr_ok_c;
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 4-channel instance plus a 3-channel
// instance sharing the write bus, so an out-of-range channel can be exercised.
module tb_clk_div_bank;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [3:0]  en      = 4'b0;
    logic        div_wr  = 1'b0;
    logic [1:0]  div_ch  = 2'd0;
    logic [16:0] div_val = 17'd0;
    logic        div_ack, div_err;
    logic [3:0]  tick, clk_out;
    logic        div_ack3, div_err3;
    logic [2:0]  tick3, clk_out3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.NUM_CH(4), .CNT_W(17), .DEFAULT_DIV(50000)) u_dut (
        .clk(clk), .rst(rst), .en(en), .div_wr(div_wr), .div_ch(div_ch),
        .div_val(div_val), .div_ack(div_ack), .div_err(div_err),
        .tick(tick), .clk_out(clk_out)
    );

    clk_div_bank #(.NUM_CH(3), .CNT_W(17), .DEFAULT_DIV(50000)) u_dut3 (
        .clk(clk), .rst(rst), .en(en[2:0]), .div_wr(div_wr), .div_ch(div_ch),
        .div_val(div_val), .div_ack(div_ack3), .div_err(div_err3),
        .tick(tick3), .clk_out(clk_out3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] every(input int first, input int period, input int n);
        logic [63:0] r;
        r = '0;
        for (int k = first; k <= n; k += period) r[k] = 1'b1;
        return r;
    endfunction

    // Disable all channels and load ch0 with v on the same edge.
    task automatic restart(input logic [16:0] v);
        en      = 4'b0000;
        div_wr  = 1'b1;
        div_ch  = 2'd0;
        div_val = v;
        step();
        div_wr = 1'b0;
        check("restart_ack", 32'(div_ack), 32'(1));
        check("restart_quiet", 32'(tick), 32'(0));
        en = 4'b0001;
    endtask

    // Run n enabled edges on ch0 against tick map tmap, with an optional write.
    task automatic run_seq(input string tag, input int n, input logic [63:0] tmap,
                           input int wr_at, input logic [1:0] wch, input logic [16:0] wval,
                           input logic eack, input logic eerr,
                           input logic eack3, input logic eerr3);
        logic co;
        co = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k == wr_at) begin
                div_wr  = 1'b1;
                div_ch  = wch;
                div_val = wval;
            end
            step();
            div_wr = 1'b0;
            if (tmap[k]) co = ~co;
            check({tag, "_tick"},    32'(tick),    32'({3'b000, tmap[k]}));
            check({tag, "_clk_out"}, 32'(clk_out), 32'({3'b000, co}));
            check({tag, "_tick3"},   32'(tick3),   32'({2'b00, tmap[k]}));
            if (k == wr_at) begin
                check({tag, "_ack"},  32'(div_ack),  32'(eack));
                check({tag, "_err"},  32'(div_err),  32'(eerr));
                check({tag, "_ack3"}, 32'(div_ack3), 32'(eack3));
                check({tag, "_err3"}, 32'(div_err3), 32'(eerr3));
            end
            if (k == wr_at + 1) begin
                check({tag, "_pulse_end"}, 32'({div_ack, div_err, div_ack3, div_err3}), 32'(0));
            end
        end
    endtask

    initial begin
        logic       early;
        logic [3:0] exp_t;
        logic [3:0] exp_c;

        // 1: async reset mid-run, then default divisor of 50000.
        step();
        step();
        rst = 1'b1;
        div_wr = 1'b1; div_ch = 2'd0; div_val = 17'd1;
        step();
        div_wr = 1'b0;
        check("wr_ack", 32'(div_ack), 32'(1));
        check("wr_err", 32'(div_err), 32'(0));
        en = 4'b0001;
        step();
        check("div1_tick", 32'(tick), 32'(4'b0001));
        check("div1_clk_out", 32'(clk_out), 32'(4'b0001));
        step();
        div_wr = 1'b1; div_ch = 2'd1; div_val = 17'd3;
        step();
        div_wr = 1'b0;
        check("pre_rst_clk_out", 32'(clk_out), 32'(4'b0001));
        check("pre_rst_ack", 32'(div_ack), 32'(1));
        #3 rst = 1'b0;
        #1;
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_clk_out", 32'(clk_out), 32'(0));
        check("rst_ack_err", 32'({div_ack, div_err}), 32'(0));
        check("rst_dut3", 32'({tick3, clk_out3, div_ack3, div_err3}), 32'(0));
        step();
        rst = 1'b1;
        early = 1'b0;
        for (int k = 1; k < 50000; k++) begin
            step();
            if (tick[0]) early = 1'b1;
        end
        check("default_no_early_tick", 32'(early), 32'(0));
        step();
        check("default_tick_50000", 32'(tick), 32'(4'b0001));

        // 2: divisor 4, other channels quiet.
        restart(17'd4);
        run_seq("div4", 12, every(4, 4, 12), 0, 2'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: write 2 mid-period; write 8 on the wrap edge.
        restart(17'd4);
        run_seq("wr2", 10, every(4, 2, 10), 2, 2'd0, 17'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        restart(17'd4);
        run_seq("wr8", 14, every(4, 8, 14), 4, 2'd0, 17'd8, 1'b1, 1'b0, 1'b1, 1'b0);

        // New divisor below current count: period completes with old divisor.
        restart(17'd8);
        run_seq("shrink", 12, every(8, 2, 12), 6, 2'd0, 17'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        // 4: rejected writes leave timing alone.
        restart(17'd4);
        run_seq("err_zero", 12, every(4, 4, 12), 2, 2'd0, 17'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        restart(17'd4);
        run_seq("err_ch", 12, every(4, 4, 12), 3, 2'd3, 17'd9, 1'b1, 1'b0, 1'b0, 1'b1);

        // 5: divisor 1, then disable mid-period at count 2 with divisor 5.
        restart(17'd1);
        run_seq("div1", 6, every(1, 1, 6), 0, 2'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        restart(17'd5);
        run_seq("div5", 7, every(5, 5, 7), 0, 2'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("div5_pre_dis_clk_out", 32'(clk_out), 32'(4'b0001));
        en = 4'b0000;
        step();
        check("dis_tick", 32'(tick), 32'(0));
        check("dis_clk_out", 32'(clk_out), 32'(0));
        en = 4'b0001;
        run_seq("reen", 10, every(5, 5, 10), 0, 2'd0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: all channels at 2,3,5,7 running together.
        en = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            div_wr  = 1'b1;
            div_ch  = 2'(c);
            div_val = (c == 0) ? 17'd2 : (c == 1) ? 17'd3 : (c == 2) ? 17'd5 : 17'd7;
            step();
            div_wr = 1'b0;
            check("multi_wr_ack", 32'(div_ack), 32'(1));
        end
        en = 4'b1111;
        exp_c = 4'b0000;
        for (int k = 1; k <= 210; k++) begin
            step();
            exp_t = {(k % 7) == 0, (k % 5) == 0, (k % 3) == 0, (k % 2) == 0};
            exp_c = exp_c ^ exp_t;
            check("multi_tick", 32'(tick), 32'(exp_t));
            check("multi_clk_out", 32'(clk_out), 32'(exp_c));
        end
        check("multi_coincide_210", 32'(tick), 32'(4'b1111));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
